sar_search_ctrl: RTL and testbench

SAR_SEARCH_CTRL -- requirements
Module: sar_search_ctrl

---
 rtl/sar_search_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sar_search_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl
// ---------------------------------------------------------------------------
// Successive-approximation search controller. It drives an 8-bit trial value
// into an external comparator (A = unknown value, B = trial). It reads the
// AltB/AeqB/AgtB flags back and resolves A one bit at a time, from the MSB
// down. A search stops early when the comparator reports equality.
//
// Optional feature: define SAR_FLAG_CHECK_EN to enable illegal-flag checking.
// Any comparator flag pattern that is not exactly one-hot then aborts the
// search and raises 'error'. In the default build, 'error' is tied low and the
// flags are resolved with priority AeqB > AgtB > AltB.
//
// Ports
//   clk      in   1  sole clock, rising edge
//   reset    in   1  synchronous active-high reset
//   start    in   1  search request, sampled only in IDLE
//   AltB     in   1  comparator: A <  trial
//   AeqB     in   1  comparator: A == trial
//   AgtB     in   1  comparator: A >  trial
//   trial    out  8  registered trial value to the comparator B input
//   busy     out  1  high in CMP and DONE
//   done     out  1  one-cycle completion pulse (state DONE)
//   result   out  8  search result, held until the next start
//   found    out  1  AeqB was seen during the search
//   probes   out  4  compare cycles used by the current/last search (0..8)
//   error    out  1  illegal-flag abort indicator
// ---------------------------------------------------------------------------
module sar_search_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       AltB,
  input  logic       AeqB,
  input  logic       AgtB,
  output logic [7:0] trial,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       found,
  output logic [3:0] probes,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] trial_q, trial_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] result_q, result_d;
  logic       found_q, found_d;
  logic [3:0] probes_q, probes_d;
  logic [7:0] acc_nxt;
  logic       flag_bad;

`ifdef SAR_FLAG_CHECK_EN
  logic       error_q, error_d;

  // The comparator must report exactly one relation per probe. Any other
  // pattern (none, or more than one flag) means the comparator or its wiring
  // is broken, so the search result cannot be trusted.
  assign flag_bad = ~((AltB & ~AeqB & ~AgtB) |
                      (~AltB & AeqB & ~AgtB) |
                      (~AltB & ~AeqB & AgtB));
  assign error    = error_q;
`else
  assign flag_bad = 1'b0;
  assign error    = 1'b0;
`endif

  // Next-state and datapath logic. Each CMP cycle is one probe. The flags
  // describe the trial value held during this cycle. A "greater" answer keeps
  // the current trial bit in the accepted bits. The next trial is then built
  // from the accepted bits plus the next lower mask bit.
  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    mask_d   = mask_q;
    acc_d    = acc_q;
    result_d = result_q;
    found_d  = found_q;
    probes_d = probes_q;
    acc_nxt  = acc_q;
`ifdef SAR_FLAG_CHECK_EN
    error_d  = error_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          trial_d  = 8'h80;
          mask_d   = 8'h80;
          acc_d    = 8'h00;
          probes_d = 4'd0;
          found_d  = 1'b0;
`ifdef SAR_FLAG_CHECK_EN
          error_d  = 1'b0;
`endif
          state_d  = CMP;
        end
      end

      CMP: begin
        probes_d = probes_q + 4'd1;
        if (flag_bad) begin
          // Abort with the bits resolved so far as the best-effort result.
`ifdef SAR_FLAG_CHECK_EN
          error_d  = 1'b1;
`endif
          result_d = acc_q;
          found_d  = 1'b0;
          state_d  = DONE;
        end else if (AeqB) begin
          result_d = trial_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else begin
          // With no flag at all, acc is kept as if AltB had been reported.
          if (AgtB) begin
            acc_nxt = trial_q;
          end else if (AltB) begin
            acc_nxt = acc_q;
          end
          acc_d = acc_nxt;
          if (mask_q == 8'h01) begin
            result_d = acc_nxt;
            found_d  = 1'b0;
            state_d  = DONE;
          end else begin
            mask_d  = mask_q >> 1;
            trial_d = acc_nxt | (mask_q >> 1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset wins over everything, including a search that is
  // in flight. An aborted search produces no done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      trial_q  <= 8'h00;
      mask_q   <= 8'h80;
      acc_q    <= 8'h00;
      result_q <= 8'h00;
      found_q  <= 1'b0;
      probes_q <= 4'd0;
`ifdef SAR_FLAG_CHECK_EN
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      mask_q   <= mask_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      found_q  <= found_d;
      probes_q <= probes_d;
`ifdef SAR_FLAG_CHECK_EN
      error_q  <= error_d;
`endif
    end
  end

  assign trial  = trial_q;
  assign busy   = (state_q == CMP) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign found  = found_q;
  assign probes = probes_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl
// ---------------------------------------------------------------------------
// Bench for sar_search_ctrl. A behavioural comparator answers for an unknown
// value A. The expected trial sequence, probe count and result are worked out
// from A directly. Trial i is the bits of A above the probe bit, plus the probe
// bit itself. The search finishes on the lowest set bit of A, or after eight
// probes when A is zero.
// ---------------------------------------------------------------------------
module tb_sar_search_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       AltB, AeqB, AgtB;
  logic [7:0] trial;
  logic       busy, done;
  logic [7:0] result;
  logic       found;
  logic [3:0] probes;
  logic       error;

  logic [7:0] a_val;
  logic       inj_bad;

  int checks   = 0;
  int failures = 0;

  sar_search_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .AltB   (AltB),
    .AeqB   (AeqB),
    .AgtB   (AgtB),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .probes (probes),
    .error  (error)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparator. inj_bad forces the illegal pattern AltB=AgtB=1.
  assign AltB = (a_val < trial) | inj_bad;
  assign AgtB = (a_val > trial) | inj_bad;
  assign AeqB = (a_val == trial) & ~inj_bad;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Trial value the search should present on probe i (1..8).
  function automatic logic [7:0] exp_trial(input int a, input int i);
    int bitv;
    bitv = 1 << (8 - i);
    return 8'((a & ~((bitv << 1) - 1) & 255) | bitv);
  endfunction

  // The search ends on the lowest set bit of A, or after 8 probes for A=0.
  function automatic int exp_probes(input int a);
    for (int k = 0; k < 8; k++) begin
      if (a[k]) return 8 - k;
    end
    return 8;
  endfunction

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_trial"},  32'(trial),  32'h00);
    checkOutput({pfx, "_result"}, 32'(result), 32'h00);
    checkOutput({pfx, "_found"},  32'(found),  32'h0);
    checkOutput({pfx, "_probes"}, 32'(probes), 32'h0);
    checkOutput({pfx, "_error"},  32'(error),  32'h0);
    checkOutput({pfx, "_busy"},   32'(busy),   32'h0);
    checkOutput({pfx, "_done"},   32'(done),   32'h0);
  endtask

  // Run one search for A=a. inject_probe > 0 forces illegal flags on that
  // probe. Trials are checked on every probe. The done cycle is checked for
  // timing and results. After done, start is raised during DONE and must be
  // ignored, and the outputs must then hold in IDLE.
  task automatic applyStimulus(input logic [7:0] a, input int inject_probe);
    int  idx;
    int  n;
    bit  seen;
    logic [7:0] exp_res;
    logic       exp_found;
    logic       exp_err;

    if (inject_probe > 0) begin
      n         = inject_probe;
      exp_res   = 8'(int'(a) & ~((2 << (8 - inject_probe)) - 1) & 255);
      exp_found = 1'b0;
      exp_err   = 1'b1;
    end else begin
      n         = exp_probes(int'(a));
      exp_res   = a;
      exp_found = (a != 8'h00);
      exp_err   = 1'b0;
    end

    @(negedge clk);
    a_val = a;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    idx  = 0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        idx++;
        checkOutput("cmp_busy", 32'(busy), 32'h1);
        checkOutput("trial", 32'(trial), 32'(exp_trial(int'(a), idx)));
        inj_bad = (idx == inject_probe);
        // A start pulse in the middle of a search must be ignored.
        start   = (idx == 2);
      end
    end
    inj_bad = 1'b0;
    start   = 1'b0;

    checkOutput("done_seen",   32'(seen),   32'h1);
    checkOutput("done_cycle",  32'(idx),    32'(n));
    checkOutput("result",      32'(result), 32'(exp_res));
    checkOutput("found",       32'(found),  32'(exp_found));
    checkOutput("probes",      32'(probes), 32'(n));
    checkOutput("error",       32'(error),  32'(exp_err));
    checkOutput("done_busy",   32'(busy),   32'h1);

    // Raise start during DONE. It must not launch a new search.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("idle_done",   32'(done),   32'h0);
      checkOutput("idle_busy",   32'(busy),   32'h0);
      checkOutput("idle_trial",  32'(trial),  32'(exp_trial(int'(a), n)));
      checkOutput("idle_result", 32'(result), 32'(exp_res));
      checkOutput("idle_probes", 32'(probes), 32'(n));
      checkOutput("idle_error",  32'(error),  32'(exp_err));
    end
  endtask

  initial begin
    a_val   = 8'h00;
    inj_bad = 1'b0;
    start   = 1'b0;
    reset   = 1'b1;

    // Reset state, with start raised to show that reset takes priority.
    repeat (2) @(posedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;

    // Directed corner cases: early exit on the first, second and last
    // probe, and the all-AltB search for zero.
    applyStimulus(8'h80, 0);
    applyStimulus(8'h40, 0);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);

    // Reset in the middle of a search for 0x55.
    @(negedge clk);
    a_val = 8'h55;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput("abort_trial", 32'(trial), 32'(exp_trial(32'h55, i)));
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 32'h0);
    end
    applyStimulus(8'h55, 0);

`ifdef SAR_FLAG_CHECK_EN
    // Illegal flags on probe 2 abort the search. The next search clears error.
    applyStimulus(8'h30, 2);
    applyStimulus(8'hC3, 5);
    applyStimulus(8'h30, 0);
`endif

    // Randomized values checked against the bit-level model.
    for (int r = 0; r < 20; r++) begin
      applyStimulus(8'($urandom_range(0, 255)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
